// File: rtl/ex_operand_stage_pkg.sv
// Shared types for the ID/EX operand stage: forwarding select, the ID/EX
// register layout and the saturating counter helper.
package ex_operand_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int OP_W    = 4;
  localparam int RADDR_W = 5;

  localparam logic [OP_W-1:0] ALU_ADD = 4'b0011;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic               valid;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;
    logic [DATA_W-1:0]  imm;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic [OP_W-1:0]    alu_op;
    logic               alu_src;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
  } id_ex_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ex_operand_stage_forward_unit.sv
// Per-operand RAW bypass select: EX/MEM beats MEM/WB, x0 is never bypassed.
module forward_unit
  import ex_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0]     rs_data,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output fwd_sel_t                  sel,
  output logic [DATA_WIDTH-1:0]     data
);

  logic rs_nz;
  assign rs_nz = (rs != '0);

  always_comb begin
    sel = FWD_NONE;
    if (rs_nz && exmem_reg_write && (exmem_rd == rs))
      sel = FWD_EXMEM;
    else if (rs_nz && memwb_reg_write && (memwb_rd == rs))
      sel = FWD_MEMWB;
  end

  always_comb begin
    data = rs_data;
    case (sel)
      FWD_EXMEM: data = exmem_result;
      FWD_MEMWB: data = memwb_result;
      default:   data = rs_data;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with stall/bubble control, operand forwarding into
// the ALU, and load-use hazard detection for the pipeline controller.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int OPCODE_LENGTH  = OP_W,
  parameter int REG_ADDR_WIDTH = RADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
  input  logic                      id_alu_src,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      load_use_hazard,
  output logic [31:0]               bubble_count
);

  id_ex_t      ex_q, load_d, bub_d;
  logic [31:0] bubble_cnt_q;
  logic        bubble;

  assign load_use_hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                           ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
  assign bubble = flush | load_use_hazard;

  always_comb begin
    load_d           = '0;
    load_d.valid     = id_valid;
    load_d.pc        = id_pc;
    load_d.rs1_data  = id_rs1_data;
    load_d.rs2_data  = id_rs2_data;
    load_d.imm       = id_imm;
    load_d.rs1       = id_rs1;
    load_d.rs2       = id_rs2;
    load_d.rd        = id_rd;
    load_d.alu_op    = id_alu_op;
    load_d.alu_src   = id_alu_src;
    load_d.reg_write = id_reg_write;
    load_d.mem_read  = id_mem_read;
    load_d.mem_write = id_mem_write;
  end

  // A bubble keeps the PC so the EX slot still reports where it sits in the stream.
  always_comb begin
    bub_d    = '0;
    bub_d.pc = ex_q.pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else if (!stall) begin
      if (bubble) begin
        ex_q         <= bub_d;
        bubble_cnt_q <= sat_inc(bubble_cnt_q);
      end else begin
        ex_q <= load_d;
      end
    end
  end

  logic [1:0][REG_ADDR_WIDTH-1:0] ex_rs;
  logic [1:0][DATA_WIDTH-1:0]     ex_rs_data;
  logic [1:0][DATA_WIDTH-1:0]     fwd_data;
  fwd_sel_t                       fwd_sel [2];

  assign ex_rs[0]      = ex_q.rs1;
  assign ex_rs[1]      = ex_q.rs2;
  assign ex_rs_data[0] = ex_q.rs1_data;
  assign ex_rs_data[1] = ex_q.rs2_data;

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    forward_unit #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd (
      .rs              (ex_rs[i]),
      .rs_data         (ex_rs_data[i]),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
      .sel             (fwd_sel[i]),
      .data            (fwd_data[i])
    );
  end

  assign SrcA          = fwd_data[0];
  assign SrcB          = ex_q.alu_src ? ex_q.imm : fwd_data[1];
  assign ex_store_data = fwd_data[1];
  assign Operation     = ex_q.alu_op;
  assign ex_pc         = ex_q.pc;
  assign ex_rd         = ex_q.rd;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign bubble_count  = bubble_cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage with hand-computed expectations.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] SrcA, SrcB, ex_store_data, ex_pc, bubble_count;
  logic [3:0]  Operation;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_store_data(ex_store_data),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .load_use_hazard(load_use_hazard), .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [4:0] rd, input logic [31:0] imm, input logic [3:0] op,
                        input logic src, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2;
    id_rs2_data = d2; id_rd = rd; id_imm = imm; id_alu_op = op; id_alu_src = src;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic fwd_set(input logic ew, input logic [4:0] erd, input logic [31:0] er,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mr);
    exmem_reg_write = ew; exmem_rd = erd; exmem_result = er;
    memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mr;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fwd_set(0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_op", {28'd0, Operation}, 32'd0);
    chk("rst_srca", SrcA, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_bub", bubble_count, 32'd0);

    // Plain ADD, no forwarding
    reset = 1'b0;
    id_set(1, 32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd5, 32'd0, 4'b0011, 0, 1, 0, 0);
    step();
    chk("add_srca", SrcA, 32'd5);
    chk("add_srcb", SrcB, 32'd7);
    chk("add_op", {28'd0, Operation}, 32'h3);
    chk("add_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_pc", ex_pc, 32'h100);
    chk("add_rd", {27'd0, ex_rd}, 32'd5);
    chk("add_store", ex_store_data, 32'd7);

    // rs1=3 forwarded from both stages; rs2=x0
    id_set(1, 32'h104, 5'd3, 32'h11, 5'd0, 32'h22, 5'd8, 32'd0, 4'b0011, 0, 1, 0, 0);
    step();
    fwd_set(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
    #1 chk("fwd_exmem_pri", SrcA, 32'hAA);
    fwd_set(0, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
    #1 chk("fwd_memwb", SrcA, 32'hBB);
    fwd_set(0, 5'd3, 32'hAA, 0, 5'd3, 32'hBB);
    #1 chk("fwd_none", SrcA, 32'h11);
    fwd_set(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
    #1 chk("x0_srcb", SrcB, 32'h22);
    chk("x0_store", ex_store_data, 32'h22);

    // Immediate operand, store data still forwarded
    fwd_set(0, 0, 0, 0, 0, 0);
    id_set(1, 32'h108, 5'd1, 32'h1, 5'd6, 32'h66, 5'd0, 32'h40, 4'b0011, 1, 0, 0, 1);
    step();
    fwd_set(1, 5'd6, 32'h77, 0, 0, 0);
    #1 chk("imm_srcb", SrcB, 32'h40);
    chk("imm_store", ex_store_data, 32'h77);
    chk("imm_mw", {31'd0, ex_mem_write}, 32'd1);
    fwd_set(0, 0, 0, 0, 0, 0);

    // lw x4 then dependent instruction
    id_set(1, 32'h10C, 5'd1, 32'h1000, 5'd0, 32'd0, 5'd4, 32'd8, 4'b0011, 1, 1, 1, 0);
    step();
    id_set(1, 32'h110, 5'd4, 32'h44, 5'd0, 32'h9, 5'd7, 32'd0, 4'b0101, 0, 1, 0, 0);
    #1 chk("lu_hazard", {31'd0, load_use_hazard}, 32'd1);
    chk("lu_mr", {31'd0, ex_mem_read}, 32'd1);
    stall = 1'b1;
    step();
    chk("lu_stall_pc", ex_pc, 32'h10C);
    chk("lu_stall_bub", bubble_count, 32'd0);
    chk("lu_stall_haz", {31'd0, load_use_hazard}, 32'd1);
    stall = 1'b0;
    step();
    chk("bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("bub_srca", SrcA, 32'd0);
    chk("bub_srcb", SrcB, 32'd0);
    chk("bub_cnt", bubble_count, 32'd1);
    chk("bub_pc", ex_pc, 32'h10C);
    chk("bub_nohaz", {31'd0, load_use_hazard}, 32'd0);
    step();
    chk("after_bub_pc", ex_pc, 32'h110);
    chk("after_bub_op", {28'd0, Operation}, 32'h5);

    // stall + flush holds for three cycles
    stall = 1'b1; flush = 1'b1;
    id_set(1, 32'h200, 5'd9, 32'h99, 5'd10, 32'hA0, 5'd11, 32'd0, 4'b0001, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sf_pc", ex_pc, 32'h110);
      chk("sf_valid", {31'd0, ex_valid}, 32'd1);
      chk("sf_cnt", bubble_count, 32'd1);
      chk("sf_rd", {27'd0, ex_rd}, 32'd7);
    end
    stall = 1'b0;
    step();
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_cnt", bubble_count, 32'd2);
    chk("fl_op", {28'd0, Operation}, 32'd0);
    chk("fl_pc", ex_pc, 32'h110);
    flush = 1'b0;
    step();
    chk("reload_pc", ex_pc, 32'h200);

    // Counter saturation
    force dut.bubble_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.bubble_cnt_q;
    #1 chk("sat_preset", bubble_count, 32'hFFFF_FFFE);
    flush = 1'b1;
    step();
    chk("sat_max", bubble_count, 32'hFFFF_FFFF);
    step();
    chk("sat_hold", bubble_count, 32'hFFFF_FFFF);
    flush = 1'b0;
    step();
    chk("sat_load_pc", ex_pc, 32'h200);

    // Reset while stalled
    stall = 1'b1; reset = 1'b1;
    step();
    chk("rs_valid", {31'd0, ex_valid}, 32'd0);
    chk("rs_pc", ex_pc, 32'd0);
    chk("rs_cnt", bubble_count, 32'd0);
    chk("rs_op", {28'd0, Operation}, 32'd0);
    chk("rs_srca", SrcA, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-resolution logic for the EX stage.
- Captures decoded operands and control from ID, holds them under stall, and inserts bubbles on flush or load-use hazard.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, then drives SrcA, SrcB and Operation into the ALU.
- Also drives the forwarded store data and a load-use hazard flag back to the pipeline controller.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OPCODE_LENGTH, 4, ALU operation code width.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  DATA_WIDTH  PC of the ID instruction.
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  register indices.
- id_alu_op  in  OPCODE_LENGTH  ALU operation code.
- id_alu_src  in  1  1 = SrcB from immediate.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- stall  in  1  hold the ID/EX register.
- flush  in  1  replace the ID/EX contents with a bubble.
- exmem_reg_write  in  1  EX/MEM writes back.
- exmem_rd  in  REG_ADDR_WIDTH  EX/MEM destination.
- exmem_result  in  DATA_WIDTH  EX/MEM ALU result.
- memwb_reg_write  in  1  MEM/WB writes back.
- memwb_rd  in  REG_ADDR_WIDTH  MEM/WB destination.
- memwb_result  in  DATA_WIDTH  MEM/WB writeback value.
- SrcA, SrcB  out  DATA_WIDTH  ALU operands after forwarding.
- Operation  out  OPCODE_LENGTH  registered ALU operation code.
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value.
- ex_pc  out  DATA_WIDTH  registered PC.
- ex_rd  out  REG_ADDR_WIDTH  registered destination.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control.
- load_use_hazard  out  1  combinational; asks the controller to stall IF/ID.
- bubble_count  out  32  saturating count of inserted bubbles.

Behaviour:
- Update priority each rising edge: reset > stall > bubble > load.
- Bubble condition: flush | load_use_hazard.
- Reset:
  - All registered fields go to 0, so Operation=0 and ex_valid=0.
  - bubble_count=0.
- Stall: all registered fields and bubble_count hold. Stall overrides load_use_hazard, keeping the load in EX.
- flush with stall: hold this cycle. The flush must be re-presented by the controller; the block does not remember it.
- Bubble:
  - All registered fields go to 0, except ex_pc, which holds.
  - Because rs1, rs2 and imm are cleared, SrcA=0 and SrcB=0 while invalid.
  - bubble_count increments, saturating at 0xFFFFFFFF.
- Load: all id_* values are captured and ex_valid is set to id_valid.
- Latency: one cycle from ID capture to the registered outputs. SrcA and SrcB are combinational from the registered values and the current forwarding inputs.
- Forwarding for operand X (rs1 or rs2):
  - If ex_rsX != 0 and exmem_reg_write and exmem_rd == ex_rsX, use exmem_result.
  - Else if ex_rsX != 0 and memwb_reg_write and memwb_rd == ex_rsX, use memwb_result.
  - Otherwise use the registered register-file data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Operand outputs:
  - SrcA = forwarded rs1.
  - SrcB = ex_alu_src ? ex_imm : forwarded rs2.
  - ex_store_data = forwarded rs2, always, regardless of ex_alu_src.
- load_use_hazard = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
- The ID register-file data is not bypassed from writeback inside this block; the register file handles write-before-read.

Decomposition:
- Shared package holds:
  - typedef fwd_sel_t {FWD_NONE, FWD_EXMEM, FWD_MEMWB}.
  - typedef id_ex_t, a packed struct of all registered fields.
  - constant ALU_ADD = 4'b0011.
- One sub-module: forward_unit, the combinational select logic, instantiated twice (rs1 and rs2).

Test Plan:
- Reset held two cycles, then id_valid=1, id_rs1_data=5, id_rs2_data=7, alu_op=ADD, no forwarding -> next cycle SrcA=5, SrcB=7, Operation=0011, ex_valid=1.
- EX instr rs1=3, exmem_reg_write=1, exmem_rd=3, exmem_result=0xAA, and memwb_rd=3 with memwb_result=0xBB -> SrcA=0xAA (EX/MEM priority).
- ex_rs2=0 with exmem_rd=0, exmem_reg_write=1, exmem_result=0x55 -> rs2 not forwarded; store data = registered value.
- EX holds lw x4 (mem_read=1, rd=4) and ID instr has rs1=4 -> load_use_hazard=1; next edge gives a bubble with ex_valid=0, SrcA=0, SrcB=0, bubble_count=1.
- stall=1 and flush=1 together for 3 cycles -> all outputs unchanged, bubble_count unchanged. stall=0 with flush=1 -> bubble.
- Force bubble_count to saturate, then flush again -> bubble_count stays 0xFFFFFFFF. Reset mid-stall -> all outputs 0 on the next edge.
